// File: rtl/sha512ctx_sched_pkg.sv
// Shared constants, state encoding and control-word layout for the
// two-context SHA512 round sequencer.
package sha512ctx_sched_pkg;

  localparam int SHA512_N_ROUNDS = 80;
  localparam int SHA512_N_WORDS  = 8;
  localparam int SLOT_W          = 7;

  // Per-context sequencer state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_POST  = 2'd3
  } state_e;

  // Control word driven to the round datapath, MSB first
  typedef struct packed {
    logic              s1_ch_rst;
    logic              s0_rst;
    logic              maj_rst;
    logic              t1_rst;
    logic              d2e_en;
    logic              block2ctx_en;
    logic              kt_zero;
    logic              wt_sel;
    logic              save_en;
    logic [2:0]        load_idx;
    logic [SLOT_W-1:0] k_round;
    logic [2:0]        save_idx;
  } ctl_t;

  // Word issued for an idle slot and held on the outputs during reset
  localparam ctl_t CTL_IDLE = '{
    s1_ch_rst:    1'b1,
    s0_rst:       1'b1,
    maj_rst:      1'b1,
    t1_rst:       1'b1,
    d2e_en:       1'b1,
    block2ctx_en: 1'b0,
    kt_zero:      1'b0,
    wt_sel:       1'b0,
    save_en:      1'b0,
    load_idx:     3'd0,
    k_round:      7'd0,
    save_idx:     3'd0
  };

endpackage

// File: rtl/sha512ctx_sched_fsm.sv
// One context's block sequencer: IDLE -> [LOAD] -> ROUND -> POST -> IDLE,
// with a 7-bit slot counter. It only advances on cycles where adv is high
// (its own phase); a start seen on the other phase is held until then.
module sha512ctx_sched_fsm
  import sha512ctx_sched_pkg::*;
#(
  parameter int N_ROUNDS = SHA512_N_ROUNDS,
  parameter int N_WORDS  = SHA512_N_WORDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       start,
  input  logic       first_blk,
  output logic [1:0] state_o,
  output logic [6:0] slot_o,
  output logic       last_o,
  output logic       busy_o
);

  state_e     state_q, state_d;
  logic [6:0] slot_q, slot_d;
  logic       hold_q, hold_d;
  logic       hfirst_q, hfirst_d;
  logic       take;
  logic       take_first;

  // State, slot counter and held start request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      hold_q   <= 1'b0;
      hfirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      hold_q   <= hold_d;
      hfirst_q <= hfirst_d;
    end
  end

  // Next-state logic; the slot counter restarts at 0 on every state change
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    hold_d     = hold_q;
    hfirst_d   = hfirst_q;
    last_o     = 1'b0;
    take       = start | hold_q;
    take_first = hold_q ? hfirst_q : first_blk;
    if (adv) begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_d = take_first ? ST_LOAD : ST_ROUND;
            slot_d  = '0;
            hold_d  = 1'b0;
          end
        end
        ST_LOAD: begin
          if (slot_q == 7'(N_WORDS - 1)) begin
            state_d = ST_ROUND;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        ST_ROUND: begin
          if (slot_q == 7'(N_ROUNDS - 1)) begin
            state_d = ST_POST;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        ST_POST: begin
          if (slot_q == 7'(N_WORDS - 1)) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            last_o  = 1'b1;
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end
      endcase
    end else if (state_q == ST_IDLE && start && !hold_q) begin
      hold_d   = 1'b1;
      hfirst_d = first_blk;
    end
  end

  assign state_o = state_q;
  assign slot_o  = slot_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/sha512ctx_sched.sv
// Sequencer for the two-context interleaved SHA512 round datapath.
// Even cycles belong to ctx0, odd cycles to ctx1; the owning context's
// state is decoded into a control word and registered onto the outputs.
module sha512ctx_sched
  import sha512ctx_sched_pkg::*;
#(
  parameter int N_ROUNDS = SHA512_N_ROUNDS,
  parameter int N_WORDS  = SHA512_N_WORDS
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [1:0] start,
  input  logic [1:0] first_blk,
  output logic [1:0] busy,
  output logic [1:0] done,
  output logic       ctx_num,
  output logic       S1_CH_rst,
  output logic       S0_rst,
  output logic       MAJ_rst,
  output logic       T1_rst,
  output logic       D2E_en,
  output logic       block2ctx_en,
  output logic [2:0] load_idx,
  output logic [6:0] k_round,
  output logic       kt_zero,
  output logic       wt_sel,
  output logic       save_en,
  output logic [2:0] save_idx
);

  logic       ph_q, ph_d;
  ctl_t       ctl_q, ctl_d;
  logic       ctx_num_q, ctx_num_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] done_q, done_d;

  logic [1:0] st0, st1;
  logic [6:0] slot0, slot1;
  logic [1:0] last;
  logic [1:0] busy_w;

  function automatic ctl_t ctl_decode(input logic [1:0] st, input logic [6:0] slot);
    ctl_t c;
    c = CTL_IDLE;
    case (state_e'(st))
      ST_LOAD: begin
        c.maj_rst      = 1'b0;
        c.block2ctx_en = 1'b1;
        c.load_idx     = slot[2:0];
      end
      ST_ROUND: begin
        c         = '0;
        c.k_round = slot;
      end
      ST_POST: begin
        c.t1_rst   = 1'b0;
        c.kt_zero  = 1'b1;
        c.wt_sel   = 1'b1;
        c.save_en  = 1'b1;
        c.save_idx = slot[2:0];
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

  sha512ctx_sched_fsm #(.N_ROUNDS(N_ROUNDS), .N_WORDS(N_WORDS)) u_fsm0 (
    .clk       (CLK),
    .rst       (rst),
    .adv       (~ph_q),
    .start     (start[0]),
    .first_blk (first_blk[0]),
    .state_o   (st0),
    .slot_o    (slot0),
    .last_o    (last[0]),
    .busy_o    (busy_w[0])
  );

  sha512ctx_sched_fsm #(.N_ROUNDS(N_ROUNDS), .N_WORDS(N_WORDS)) u_fsm1 (
    .clk       (CLK),
    .rst       (rst),
    .adv       (ph_q),
    .start     (start[1]),
    .first_blk (first_blk[1]),
    .state_o   (st1),
    .slot_o    (slot1),
    .last_o    (last[1]),
    .busy_o    (busy_w[1])
  );

  // Phase selects the owning context; done trails the last POST word by one cycle
  always_comb begin
    ph_d      = ~ph_q;
    ctl_d     = ph_q ? ctl_decode(st1, slot1) : ctl_decode(st0, slot0);
    ctx_num_d = ph_q;
    pend_d    = last;
    done_d    = pend_q;
  end

  // Output register stage
  always_ff @(posedge CLK) begin
    if (rst) begin
      ph_q      <= 1'b0;
      ctl_q     <= CTL_IDLE;
      ctx_num_q <= 1'b0;
      pend_q    <= '0;
      done_q    <= '0;
    end else begin
      ph_q      <= ph_d;
      ctl_q     <= ctl_d;
      ctx_num_q <= ctx_num_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
    end
  end

  assign busy         = busy_w;
  assign done         = done_q;
  assign ctx_num      = ctx_num_q;
  assign S1_CH_rst    = ctl_q.s1_ch_rst;
  assign S0_rst       = ctl_q.s0_rst;
  assign MAJ_rst      = ctl_q.maj_rst;
  assign T1_rst       = ctl_q.t1_rst;
  assign D2E_en       = ctl_q.d2e_en;
  assign block2ctx_en = ctl_q.block2ctx_en;
  assign load_idx     = ctl_q.load_idx;
  assign k_round      = ctl_q.k_round;
  assign kt_zero      = ctl_q.kt_zero;
  assign wt_sel       = ctl_q.wt_sel;
  assign save_en      = ctl_q.save_en;
  assign save_idx     = ctl_q.save_idx;

endmodule
